// File: rtl/fetch_controller.sv
// fetch_controller
//   Sequences instruction fetch from a byte-addressed, big-endian instruction
//   memory whose read path is combinational. The block owns the PC and drives
//   it as the memory address. Each fetched 32-bit word goes into a 2-entry
//   fetch buffer. The buffer head is presented to decode over a valid/ready
//   handshake. Branch redirects flush the buffer and reload the PC. An
//   all-zero instruction word puts the controller into a halt state.
//
//   Optional feature macro: FETCH_FAULT_EN
//     When defined, each fetch first checks the PC for misalignment or an
//     out-of-range address. A faulting fetch pushes a NOP marked with a fault
//     bit and then halts. When undefined, out_fault is tied 0 and every
//     address goes to memory unchanged.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high
//   imem_addr      out  64  byte address to instruction memory (= pc)
//   imem_instr     in   32  word returned combinationally by memory
//   redirect_valid in   1   branch/jump redirect request
//   redirect_pc    in   64  redirect target
//   out_valid      out  1   buffer head valid toward decode
//   out_ready      in   1   decode accepts head
//   out_pc         out  64  pc of head entry (0 when buffer empty)
//   out_instr      out  32  instruction of head entry (0 when buffer empty)
//   out_fault      out  1   head entry carries a fetch fault
//   halted         out  1   controller is halted
module fetch_controller #(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter int unsigned MEM_SIZE = 4095
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    output logic        halted
);

`ifdef FETCH_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    // Highest PC at which a full 4-byte word still lies inside memory.
    localparam logic [63:0] LAST_WORD = 64'(MEM_SIZE) - 64'd4;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;

    // Slot 0 is always the head; slot 1 is valid only when count_q == 2.
    logic [63:0] ent_pc_q    [2];
    logic [31:0] ent_instr_q [2];
    logic        ent_fault_q [2];

    logic        redirect_take;
    logic        pop;
    logic        push;
    logic        fetch_fault;
    logic        zero_word;
    logic        wr_en;
    logic [31:0] wr_instr;
    logic [1:0]  fill;

    // A redirect in S_BOOT is ignored. A redirect still blocks
    // acceptance of the head through out_valid.
    assign redirect_take = redirect_valid && (state_q != S_BOOT);
    assign pop           = out_valid && out_ready;
    assign push          = (state_q == S_RUN) && !redirect_valid &&
                           ((count_q < 2'd2) || pop);
    assign fetch_fault   = FAULT_EN && ((pc_q[1:0] != 2'b00) || (pc_q > LAST_WORD));
    assign zero_word     = (imem_instr == 32'h0);
    // A zero word consumes the push slot but writes nothing. A fault always writes.
    assign wr_en         = push && (fetch_fault || !zero_word);
    assign wr_instr      = fetch_fault ? NOP_WORD : imem_instr;
    // Occupancy after this cycle's pop; that is where a new word lands.
    assign fill          = count_q - {1'b0, pop};

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (redirect_valid) begin
                    state_d = S_RUN;
                end else if (push && (fetch_fault || zero_word)) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        halted    = (state_q == S_HALT);
        imem_addr = pc_q;
        out_valid = (count_q != 2'd0) && !redirect_valid;
        out_pc    = 64'h0;
        out_instr = 32'h0;
        out_fault = 1'b0;
        if (count_q != 2'd0) begin
            out_pc    = ent_pc_q[0];
            out_instr = ent_instr_q[0];
            out_fault = FAULT_EN && ent_fault_q[0];
        end
    end

    // PC and occupancy next-state. A redirect overrides both push and pop.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        if (redirect_take) begin
            pc_d    = redirect_pc;
            count_d = 2'd0;
        end else begin
            count_d = fill + {1'b0, wr_en};
            if (wr_en && !fetch_fault) begin
                pc_d = pc_q + 64'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Buffer payload carries no reset; count_q alone qualifies it.
    // pop and wr_en are both low while redirect_valid is high.
    always_ff @(posedge clk) begin
        if (wr_en && (fill == 2'd0)) begin
            ent_pc_q[0]    <= pc_q;
            ent_instr_q[0] <= wr_instr;
            ent_fault_q[0] <= fetch_fault;
        end else if (pop && (count_q == 2'd2)) begin
            ent_pc_q[0]    <= ent_pc_q[1];
            ent_instr_q[0] <= ent_instr_q[1];
            ent_fault_q[0] <= ent_fault_q[1];
        end
        if (wr_en && (fill == 2'd1)) begin
            ent_pc_q[1]    <= pc_q;
            ent_instr_q[1] <= wr_instr;
            ent_fault_q[1] <= fetch_fault;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    localparam logic [63:0] PC_RESET = 64'h0;
    localparam int unsigned MEM_SIZE = 4095;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        halted;

    logic [7:0]  mem [0:4095];

    int checks   = 0;
    int failures = 0;

    entry_t      mq[$];
    logic [63:0] mpc;
    int          mmode;
    bit          model_ok = 0;
    logic [63:0] dlog[$];

    fetch_controller #(.PC_RESET(PC_RESET), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .out_fault(out_fault),
        .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Big-endian combinational memory; bytes past MEM_SIZE read as zero.
    function automatic logic [31:0] rd(input logic [63:0] a);
        logic [31:0] w;
        logic [63:0] b;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b = a + 64'(i);
            w = w << 8;
            if (b < 64'(MEM_SIZE)) w[7:0] = mem[b[11:0]];
        end
        return w;
    endfunction

    assign imem_instr = rd(imem_addr);

    task automatic put(input int a, input logic [31:0] w);
        mem[a]   = w[31:24];
        mem[a+1] = w[23:16];
        mem[a+2] = w[15:8];
        mem[a+3] = w[7:0];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm, input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input int n);
        logic [63:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({nm, "_count"}, 64'(dlog.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < dlog.size()) chk({nm, "_pc"}, dlog[i], e[i]);
        end
    endtask

    // Reference model: a queue of pending entries plus a PC and a mode.
    always @(posedge clk) begin : model
        int          n;
        bit          take;
        bit          can;
        bit          flt;
        logic [31:0] w;
        if (reset) begin
            mq.delete();
            mpc      = PC_RESET;
            mmode    = M_BOOT;
            model_ok = 1;
        end else if (mmode == M_BOOT) begin
            mmode = M_RUN;
        end else if (redirect_valid) begin
            mq.delete();
            mpc   = redirect_pc;
            mmode = M_RUN;
        end else begin
            n    = mq.size();
            take = (n > 0) && out_ready;
            can  = (mmode == M_RUN) && ((n < 2) || take);
            if (take) void'(mq.pop_front());
            if (can) begin
                w   = rd(mpc);
                flt = 0;
`ifdef FETCH_FAULT_EN
                flt = (mpc[1:0] != 2'b00) || (mpc > 64'(MEM_SIZE - 4));
`endif
                if (flt) begin
                    mq.push_back('{mpc, 32'h13, 1'b1});
                    mmode = M_HALT;
                end else if (w != 32'h0) begin
                    mq.push_back('{mpc, w, 1'b0});
                    mpc = mpc + 64'd4;
                end else begin
                    mmode = M_HALT;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        entry_t e;
        bit     ev;
        if (model_ok) begin
            ev = (mq.size() != 0) && !redirect_valid;
            if (mq.size() != 0) e = mq[0];
            else e = '{64'h0, 32'h0, 1'b0};
            chk("cmp_valid", 64'(out_valid), 64'(ev));
            chk("cmp_pc", out_pc, e.pc);
            chk("cmp_instr", 64'(out_instr), 64'(e.instr));
            chk("cmp_fault", 64'(out_fault), 64'(e.fault));
            chk("cmp_halted", 64'(halted), 64'(mmode == M_HALT));
            chk("cmp_addr", imem_addr, mpc);
            if (out_valid && out_ready) dlog.push_back(out_pc);
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h0;
        put(32'h00, 32'h00500093);
        put(32'h04, 32'h00A00113);
        put(32'h08, 32'h00F00193);
        put(32'h0C, 32'h00000000);
        put(32'h40, 32'h00100013);
        put(32'h44, 32'h00200013);
        put(32'h48, 32'h00000000);

        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
        tick(2);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(out_fault), 64'd0);
        chk("rst_addr", imem_addr, PC_RESET);

        // Basic latency and back-to-back delivery
        reset = 1'b0; out_ready = 1'b1;
        chk("t1_c0_valid", 64'(out_valid), 64'd0);
        tick(1);
        chk("t1_c1_valid", 64'(out_valid), 64'd0);
        chk("t1_c1_addr", imem_addr, 64'h0);
        tick(1);
        chk("t1_c2_valid", 64'(out_valid), 64'd1);
        chk("t1_c2_pc", out_pc, 64'h0);
        chk("t1_c2_instr", 64'(out_instr), 64'h00500093);
        tick(1);
        chk("t1_c3_valid", 64'(out_valid), 64'd1);
        chk("t1_c3_pc", out_pc, 64'h4);
        chk("t1_c3_instr", 64'(out_instr), 64'h00A00113);
        tick(6);

        // Backpressure saturation, then drain to the zero-word halt
        reset = 1'b1; out_ready = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(5);
        chk("t2_addr_hold", imem_addr, 64'h8);
        chk("t2_head_pc", out_pc, 64'h0);
        chk("t2_valid", 64'(out_valid), 64'd1);
        dlog.delete();
        out_ready = 1'b1;
        tick(8);
        chk_log("t2_log", 64'h0, 64'h4, 64'h8, 3);
        chk("t4_halted", 64'(halted), 64'd1);
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_addr", imem_addr, 64'hC);

        // Redirect out of halt restarts fetch from the target
        dlog.delete();
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        tick(1);
        redirect_valid = 1'b0;
        chk("t4_unhalt", 64'(halted), 64'd0);
        chk("t4_readdr", imem_addr, 64'h0);
        tick(6);
        chk_log("t4_log", 64'h0, 64'h4, 64'h8, 3);
        chk("t4_rehalt", 64'(halted), 64'd1);

        // Redirect with a full buffer
        reset = 1'b1; out_ready = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(5);
        dlog.delete();
        redirect_valid = 1'b1; redirect_pc = 64'h40; out_ready = 1'b1;
        #1;
        chk("t3_redir_valid", 64'(out_valid), 64'd0);
        tick(1);
        redirect_valid = 1'b0; out_ready = 1'b0;
        chk("t3_noaccept", 64'(dlog.size()), 64'd0);
        chk("t3_empty", 64'(out_valid), 64'd0);
        chk("t3_addr", imem_addr, 64'h40);
        tick(1);
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_pc", out_pc, 64'h40);
        chk("t3_instr", 64'(out_instr), 64'h00100013);
        out_ready = 1'b1;
        tick(4);
        chk_log("t3_log", 64'h40, 64'h44, 64'h0, 2);
        chk("t3_halted", 64'(halted), 64'd1);

        // Reset mid-stream with a full buffer
        reset = 1'b1; out_ready = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_addr", imem_addr, PC_RESET);
        chk("t6_halted", 64'(halted), 64'd0);
        reset = 1'b0; out_ready = 1'b1;
        tick(8);

        // Misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 64'h6;
        tick(1);
        redirect_valid = 1'b0;
        chk("t5_addr", imem_addr, 64'h6);
        tick(1);
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_pc", out_pc, 64'h6);
`ifdef FETCH_FAULT_EN
        chk("t5_instr", 64'(out_instr), 64'h13);
        chk("t5_fault", 64'(out_fault), 64'd1);
        chk("t5_halted", 64'(halted), 64'd1);
        chk("t5_pc_hold", imem_addr, 64'h6);
        tick(2);
        redirect_valid = 1'b1; redirect_pc = 64'hFFC;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        chk("t5_oor_pc", out_pc, 64'hFFC);
        chk("t5_oor_fault", 64'(out_fault), 64'd1);
        chk("t5_oor_halted", 64'(halted), 64'd1);
`else
        chk("t5_instr", 64'(out_instr), 64'h011300F0);
        chk("t5_fault", 64'(out_fault), 64'd0);
        tick(1);
        chk("t5_next_pc", out_pc, 64'hA);
        chk("t5_next_instr", 64'(out_instr), 64'h01930000);
        tick(3);
        chk("t5_halted", 64'(halted), 64'd1);
        chk("t5_halt_addr", imem_addr, 64'hE);
`endif
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
